// File: rtl/led_fade_driver.sv
// RGB LED output stage: each colour bit sets a full/off brightness target, duties
// ramp linearly toward it one step per prescaler tick and are rendered as PWM.
module led_fade_driver #(
    parameter int PWM_BITS = 8,
    parameter int STEP_DIV = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] colour,
    input  logic       enable,
    output logic       led_r,
    output logic       led_g,
    output logic       led_b,
    output logic       busy
);

    localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PWM_BITS-1:0] MAX     = '1;
    localparam logic [PWM_BITS-1:0] ZERO    = '0;
    localparam logic [PWM_BITS-1:0] ONE     = PWM_BITS'(1);
    localparam logic [PW-1:0]       PRE_TOP = PW'(STEP_DIV - 1);
    localparam logic [PW-1:0]       PRE_ONE = PW'(1);

    logic [2:0]          colour_q;
    logic [PW-1:0]       pre_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] duty      [3];
    logic [PWM_BITS-1:0] duty_next [3];
    logic [PWM_BITS-1:0] tgt       [3];
    logic [2:0]          led_next;
    logic [2:0]          led_q;
    logic                busy_next;
    logic                tick;

    assign tick = (pre_cnt == PRE_TOP);

    // Steps use the registered colour, so a colour change on a tick edge is not seen yet.
    always_comb begin
        busy_next = 1'b0;
        led_next  = 3'b000;
        for (int i = 0; i < 3; i++) begin
            tgt[i]       = (colour_q[i] && enable) ? MAX : ZERO;
            duty_next[i] = duty[i];
            if (!enable) begin
                duty_next[i] = ZERO;
            end else if (tick) begin
                if (duty[i] < tgt[i]) begin
                    duty_next[i] = duty[i] + ONE;
                end else if (duty[i] > tgt[i]) begin
                    duty_next[i] = duty[i] - ONE;
                end
            end
            led_next[i] = enable && ((duty[i] == MAX) || (pwm_cnt < duty[i]));
            if (duty_next[i] != tgt[i]) begin
                busy_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            colour_q <= 3'b000;
            pre_cnt  <= '0;
            pwm_cnt  <= '0;
            led_q    <= 3'b000;
            busy     <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                duty[i] <= ZERO;
            end
        end else begin
            colour_q <= colour;
            pre_cnt  <= tick ? '0 : pre_cnt + PRE_ONE;
            pwm_cnt  <= pwm_cnt + ONE;
            led_q    <= led_next;
            busy     <= busy_next;
            for (int i = 0; i < 3; i++) begin
                duty[i] <= duty_next[i];
            end
        end
    end

    assign led_r = led_q[0];
    assign led_g = led_q[1];
    assign led_b = led_q[2];

endmodule
